// File: rtl/md_rom_loader.sv
// md_rom_loader: packs the iosys loader byte stream into SDRAM words and hands them to a
// toggle req/ack write port through a 2-entry queue; also reports load size and gates the core.
module md_rom_loader #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 25,
    parameter bit                BIG_ENDIAN = 1'b1,
    parameter logic [ADDR_W-1:0] BASE_1     = 25'h0000000,
    parameter logic [ADDR_W-1:0] BASE_2     = 25'h0820000,
    parameter logic [ADDR_W-1:0] BASE_3     = 25'h0830000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [2:0]                          loading,
    input  logic [7:0]                          do_data,
    input  logic                                do_valid,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]  mem_addr,
    output logic [DATA_W-1:0]                   mem_wdata,
    output logic [DATA_W/8-1:0]                 mem_be,
    output logic                                mem_req,
    input  logic                                mem_ack,
    output logic                                core_on,
    output logic [ADDR_W-1:0]                   rom_size,
    output logic                                done,
    output logic                                overflow
);

    localparam int LANES   = DATA_W / 8;
    localparam int LSB     = $clog2(LANES);
    localparam int WADDR_W = ADDR_W - LSB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] place_byte(input logic [DATA_W-1:0] word,
                                                     input logic [7:0]        data,
                                                     input logic [LSB-1:0]    lane);
        logic [DATA_W-1:0] res;
        int                pos;
        res = word;
        pos = BIG_ENDIAN ? (LANES - 1 - int'(lane)) : int'(lane);
        res[pos*8 +: 8] = data;
        return res;
    endfunction

    function automatic logic [LANES-1:0] fill_be(input logic [LSB-1:0] filled);
        logic [LANES-1:0] res;
        res = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(filled)) begin
                res[BIG_ENDIAN ? (LANES - 1 - k) : k] = 1'b1;
            end
        end
        return res;
    endfunction

    // Loading codes 4..7 fall back to the cartridge ROM region.
    function automatic logic [ADDR_W-1:0] region_base(input logic [2:0] sel);
        logic [ADDR_W-1:0] res;
        case (sel)
            3'd2:    res = BASE_2;
            3'd3:    res = BASE_3;
            default: res = BASE_1;
        endcase
        return res;
    endfunction

    state_t               state_r;
    state_t               state_n;
    logic [2:0]           loading_prev_r;
    logic [WADDR_W-1:0]   base_w_r;
    logic [ADDR_W-1:0]    count_r;
    logic [DATA_W-1:0]    word_r;
    logic                 flushed_r;
    logic                 pending_r;
    logic                 ack_prev_r;

    logic [WADDR_W-1:0]   fifo_addr_r [2];
    logic [DATA_W-1:0]    fifo_data_r [2];
    logic [LANES-1:0]     fifo_be_r   [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           fifo_cnt_r;

    logic [LSB-1:0]       lane_s;
    logic                 sat_s;
    logic                 last_lane_s;
    logic                 start_s;
    logic                 byte_s;
    logic                 accept_s;
    logic [DATA_W-1:0]    packed_s;
    logic                 tail_s;
    logic                 push_s;
    logic                 push_ok_s;
    logic [WADDR_W-1:0]   push_addr_s;
    logic [DATA_W-1:0]    push_data_s;
    logic [LANES-1:0]     push_be_s;
    logic                 ack_edge_s;
    logic                 ready_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 flush_done_s;
    logic [ADDR_W-1:0]    base_sel_s;

    // Byte packing, queue push/pop decisions and port readiness.
    always_comb begin
        lane_s       = count_r[LSB-1:0];
        sat_s        = &count_r;
        last_lane_s  = &lane_s;
        start_s      = (state_r == ST_IDLE) && (loading != 3'd0) && (loading_prev_r == 3'd0);
        byte_s       = (state_r == ST_LOAD) && do_valid;
        accept_s     = byte_s && !sat_s;
        packed_s     = place_byte((lane_s == {LSB{1'b0}}) ? {DATA_W{1'b0}} : word_r, do_data, lane_s);
        tail_s       = (state_r == ST_FLUSH) && !flushed_r && (lane_s != {LSB{1'b0}});
        push_s       = (accept_s && last_lane_s) || tail_s;
        push_addr_s  = base_w_r + count_r[ADDR_W-1:LSB];
        if (tail_s) begin
            push_data_s = word_r;
            push_be_s   = fill_be(lane_s);
        end else begin
            push_data_s = packed_s;
            push_be_s   = {LANES{1'b1}};
        end
        // Completion is an ack toggle, so a stale ack from before reset cannot match a new request level.
        ack_edge_s   = (mem_ack != ack_prev_r);
        ready_s      = !pending_r || ack_edge_s;
        pop_s        = (fifo_cnt_r != 2'd0) && ready_s;
        push_ok_s    = push_s && ((fifo_cnt_r != 2'd2) || pop_s);
        drop_s       = (push_s && !push_ok_s) || (byte_s && sat_s);
        flush_done_s = (state_r == ST_FLUSH) && flushed_r && (fifo_cnt_r == 2'd0) && !pending_r;
        base_sel_s   = region_base(loading);
    end

    // Load sequencing: idle, accept bytes, drain the tail, then a single done cycle.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (loading == 3'd0) begin
                    state_n = ST_FLUSH;
                end else begin
                    state_n = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_done_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_FLUSH;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Per-load bookkeeping: region, byte count, word assembly and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            loading_prev_r <= 3'd0;
            base_w_r       <= {WADDR_W{1'b0}};
            count_r        <= {ADDR_W{1'b0}};
            word_r         <= {DATA_W{1'b0}};
            flushed_r      <= 1'b0;
            overflow       <= 1'b0;
            core_on        <= 1'b0;
            rom_size       <= {ADDR_W{1'b0}};
            done           <= 1'b0;
        end else begin
            loading_prev_r <= loading;
            done           <= flush_done_s;
            if (start_s) begin
                base_w_r  <= base_sel_s[ADDR_W-1:LSB];
                count_r   <= {ADDR_W{1'b0}};
                word_r    <= {DATA_W{1'b0}};
                flushed_r <= 1'b0;
                overflow  <= 1'b0;
                core_on   <= 1'b0;
            end else begin
                if (accept_s) begin
                    count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    word_r  <= packed_s;
                end
                if (state_r == ST_FLUSH) begin
                    flushed_r <= 1'b1;
                end
                if (drop_s) begin
                    overflow <= 1'b1;
                end
                if (flush_done_s) begin
                    core_on  <= 1'b1;
                    rom_size <= count_r;
                end
            end
        end
    end

    // Queue pointers and the write port; one request in flight, fields held until acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            fifo_cnt_r <= 2'd0;
            pending_r  <= 1'b0;
            ack_prev_r <= mem_ack;
            mem_req    <= 1'b0;
            mem_addr   <= {WADDR_W{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
            mem_be     <= {LANES{1'b0}};
        end else begin
            ack_prev_r <= mem_ack;
            if (push_ok_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r  <= ~rd_ptr_r;
                mem_addr  <= fifo_addr_r[rd_ptr_r];
                mem_wdata <= fifo_data_r[rd_ptr_r];
                mem_be    <= fifo_be_r[rd_ptr_r];
                mem_req   <= ~mem_req;
                pending_r <= 1'b1;
            end else if (ack_edge_s) begin
                pending_r <= 1'b0;
            end
            case ({push_ok_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Queue storage; occupancy is tracked separately so contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_addr_r[wr_ptr_r] <= push_addr_s;
            fifo_data_r[wr_ptr_r] <= push_data_s;
            fifo_be_r[wr_ptr_r]   <= push_be_s;
        end
    end

endmodule

// File: tb/tb_md_rom_loader.sv
// Bench for md_rom_loader: a 16-bit big-endian and a 32-bit little-endian instance share the
// byte stream; each has its own SDRAM responder, results are compared with a byte-level model.
module tb_md_rom_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  loading;
    logic [7:0]  do_data;
    logic        do_valid;

    logic [23:0] a_addr;
    logic [15:0] a_wdata;
    logic [1:0]  a_be;
    logic        a_req;
    logic        a_ack = 1'b0;
    logic        a_core_on;
    logic [24:0] a_rom_size;
    logic        a_done;
    logic        a_ovf;

    logic [22:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        b_req;
    logic        b_ack = 1'b0;
    logic        b_core_on;
    logic [24:0] b_rom_size;
    logic        b_done;
    logic        b_ovf;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          delay_cyc = 1;
    int          a_cnt = 0, b_cnt = 0;
    int          a_done_n = 0, b_done_n = 0;
    logic        a_seen = 1'b0, b_seen = 1'b0;
    logic [7:0]  tx_bytes [$];
    wr_t         got_a [$];
    wr_t         got_b [$];
    wr_t         exp_a [$];
    wr_t         exp_b [$];

    always #5 clk = ~clk;

    md_rom_loader #(.DATA_W(16), .ADDR_W(25), .BIG_ENDIAN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .loading(loading), .do_data(do_data), .do_valid(do_valid),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_be(a_be), .mem_req(a_req), .mem_ack(a_ack),
        .core_on(a_core_on), .rom_size(a_rom_size), .done(a_done), .overflow(a_ovf)
    );

    md_rom_loader #(.DATA_W(32), .ADDR_W(25), .BIG_ENDIAN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .loading(loading), .do_data(do_data), .do_valid(do_valid),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_be(b_be), .mem_req(b_req), .mem_ack(b_ack),
        .core_on(b_core_on), .rom_size(b_rom_size), .done(b_done), .overflow(b_ovf)
    );

    // SDRAM responders: log each new request level, toggle ack delay_cyc cycles later.
    always @(negedge clk) begin : sdram_a
        wr_t w;
        if (a_cnt > 0) begin
            a_cnt = a_cnt - 1;
            if (a_cnt == 0) a_ack = ~a_ack;
        end
        if (reset) begin
            a_seen = 1'b0;
        end else if (a_req != a_seen) begin
            a_seen = a_req;
            w.addr = {8'h00, a_addr};
            w.data = {16'h0000, a_wdata};
            w.be   = {2'b00, a_be};
            got_a.push_back(w);
            a_cnt = delay_cyc;
        end
        if (a_done) a_done_n = a_done_n + 1;
    end

    always @(negedge clk) begin : sdram_b
        wr_t w;
        if (b_cnt > 0) begin
            b_cnt = b_cnt - 1;
            if (b_cnt == 0) b_ack = ~b_ack;
        end
        if (reset) begin
            b_seen = 1'b0;
        end else if (b_req != b_seen) begin
            b_seen = b_req;
            w.addr = {9'h000, b_addr};
            w.data = b_wdata;
            w.be   = b_be;
            got_b.push_back(w);
            b_cnt = delay_cyc;
        end
        if (b_done) b_done_n = b_done_n + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input logic [2:0] region);
        case (region)
            3'd2:    return 32'h0082_0000;
            3'd3:    return 32'h0083_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Reference: byte i goes to word i/lanes, lane i%lanes; lane order set by endianness.
    task automatic build_expected(input int idx, input int lanes, input bit big,
                                  input logic [31:0] base, input int nb);
        wr_t         w;
        int          pos;
        int          bi;
        int          nw;
        logic [31:0] mask;
        mask = (lanes == 2) ? 32'h00FF_FFFF : 32'h007F_FFFF;
        nw   = (nb + lanes - 1) / lanes;
        if (idx == 0) exp_a.delete(); else exp_b.delete();
        for (int wi = 0; wi < nw; wi++) begin
            w.addr = (base / 32'(lanes) + 32'(wi)) & mask;
            w.data = 32'h0;
            w.be   = 4'h0;
            for (int k = 0; k < lanes; k++) begin
                bi = wi * lanes + k;
                if (bi < nb) begin
                    pos = big ? (lanes - 1 - k) : k;
                    w.data[pos*8 +: 8] = tx_bytes[bi];
                    w.be[pos] = 1'b1;
                end
            end
            if (idx == 0) exp_a.push_back(w); else exp_b.push_back(w);
        end
    endtask

    task automatic compare_writes(input int idx);
        wr_t g [$];
        wr_t e [$];
        if (idx == 0) begin g = got_a; e = exp_a; end
        else begin g = got_b; e = exp_b; end
        check_eq($sformatf("wr_count_%0d", idx), 64'(g.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            check_eq($sformatf("wr_%0d_%0d", idx, i), {g[i].addr[23:0], g[i].data, g[i].be},
                     {e[i].addr[23:0], e[i].data, e[i].be});
        end
    endtask

    task automatic run_load(input logic [2:0] region, input int gap_max, input int switch_at,
                            input int a_keep, input bit exp_ovf_a);
        int n;
        int t;
        n = tx_bytes.size();
        got_a.delete();
        got_b.delete();
        a_done_n = 0;
        b_done_n = 0;
        @(negedge clk) loading = region;
        repeat (2) @(negedge clk);
        check_eq("core_off_in_load", {a_core_on, b_core_on}, 64'h0);
        for (int i = 0; i < n; i++) begin
            if (i == switch_at) loading = 3'd3;
            do_data  = tx_bytes[i];
            do_valid = 1'b1;
            @(negedge clk);
            do_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
        loading = 3'd0;
        t = 0;
        while ((a_done_n == 0 || b_done_n == 0) && t < 600) begin
            @(negedge clk);
            t = t + 1;
        end
        check_eq("done_within_budget", 64'(t < 600), 64'h1);
        repeat (3) @(negedge clk);
        build_expected(0, 2, 1'b1, base_of(region), a_keep);
        build_expected(1, 4, 1'b0, base_of(region), n);
        compare_writes(0);
        compare_writes(1);
        check_eq("rom_size_a", 64'(a_rom_size), 64'(n));
        check_eq("rom_size_b", 64'(b_rom_size), 64'(n));
        check_eq("overflow", {a_ovf, b_ovf}, {62'h0, exp_ovf_a, 1'b0});
        check_eq("core_on_after", {a_core_on, b_core_on}, 64'h3);
        check_eq("done_pulses", {32'(a_done_n), 32'(b_done_n)}, {32'd1, 32'd1});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [2:0]  region;
        logic [24:0] rs_a, rs_b;
        reset    = 1'b1;
        loading  = 3'd0;
        do_data  = 8'h00;
        do_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_a", {a_req, a_core_on, a_done, a_ovf, a_rom_size}, 64'h0);
        check_eq("reset_b", {b_req, b_core_on, b_done, b_ovf, b_rom_size}, 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        delay_cyc = 3;
        tx_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(3'd1, 2, -1, 4, 1'b0);

        tx_bytes = '{8'hAB, 8'hCD, 8'hEF};
        run_load(3'd1, 1, -1, 3, 1'b0);

        delay_cyc = 1;
        tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(3'd2, 0, -1, 4, 1'b0);

        // Stalled port with back-to-back bytes: 16-bit side keeps three words, drops the fourth.
        delay_cyc = 20;
        tx_bytes.delete();
        for (int i = 0; i < 8; i++) tx_bytes.push_back(8'($urandom));
        run_load(3'd1, 0, -1, 6, 1'b1);

        // Reset in the middle of a load with a request still outstanding.
        tx_bytes.delete();
        for (int i = 0; i < 5; i++) tx_bytes.push_back(8'($urandom));
        @(negedge clk) loading = 3'd1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            do_data  = tx_bytes[i];
            do_valid = 1'b1;
            @(negedge clk);
        end
        do_valid = 1'b0;
        reset    = 1'b1;
        loading  = 3'd0;
        @(negedge clk);
        check_eq("midrst_a", {a_req, a_core_on, a_done, a_ovf, a_rom_size}, 64'h0);
        check_eq("midrst_b", {b_req, b_core_on, b_done, b_ovf, b_rom_size}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        got_a.delete();
        got_b.delete();
        repeat (30) @(negedge clk);
        check_eq("midrst_no_issue", {a_req, b_req, 16'(got_a.size()), 16'(got_b.size())}, 64'h0);
        delay_cyc = 1;

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(20, 1);
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            case ($urandom_range(4, 0))
                0:       region = 3'd1;
                1:       region = 3'd2;
                2:       region = 3'd3;
                3:       region = 3'd5;
                default: region = 3'd7;
            endcase
            if (r == 0) run_load(3'd1, 2, n / 2, n, 1'b0);
            else        run_load(region, 2, -1, n, 1'b0);
        end

        // Bytes while not loading must be ignored entirely.
        rs_a = a_rom_size;
        rs_b = b_rom_size;
        got_a.delete();
        got_b.delete();
        for (int i = 0; i < 6; i++) begin
            do_data  = 8'($urandom);
            do_valid = 1'b1;
            @(negedge clk);
        end
        do_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("idle_no_writes", {16'(got_a.size()), 16'(got_b.size())}, 64'h0);
        check_eq("idle_rom_size", {a_rom_size, b_rom_size}, {rs_a, rs_b});
        check_eq("idle_flags", {a_ovf, b_ovf, a_core_on, b_core_on}, 64'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
